uart_tx_frame: RTL and testbench

- UART transmitter, the transmit-side counterpart of the UART RX path.
- Accepts a parallel byte with a valid strobe and serialises one frame on TX_OUT: start bit, DATA_WIDTH data bits LSB first, optional parity bit, one stop bit.
- Runs on the oversampled UART clock; an internal prescale counter sets the bit period, so TX and RX share one Prescale configuration.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_frame_if.sv | 16 +
 rtl/uart_tx_parity.sv | 12 +
 rtl/uart_tx_frame.sv | 98 +++++++++
 tb/tb_uart_tx_frame.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state codes, parity types and defaults for the TX/RX paths.
package uart_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b011,
    PARITY = 3'b010,
    STOP   = 3'b110
  } uart_state_e;
  function automatic logic [5:0] eff_prescale(input logic [5:0] p);
    return (p == 6'd0) ? 6'd1 : p;
  endfunction
endpackage

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: parallel request side and serial line of the UART transmitter.
interface uart_tx_frame_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [5:0]            Prescale;
  logic                  TX_OUT;
  logic                  Busy;
  modport master(output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale, input TX_OUT, Busy);
  modport slave(input P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale, output TX_OUT, Busy);
endinterface

// File: rtl/uart_tx_parity.sv
// uart_tx_parity: parity bit of a data word, even or odd; shared with the RX checker.
module uart_tx_parity
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  par_o
);
  assign par_o = (^data_i) ^ (par_typ_i == PAR_ODD);
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: serialises one byte as start, data (LSB first), optional parity and stop bit,
// each bit held for the latched Prescale clk cycles.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input logic            clk,
  input logic            rst_n,
  uart_tx_frame_if.slave bus
);
  uart_state_e           state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [5:0]            pre_q, pre_d;
  logic [3:0]            bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  par_en_q, par_en_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  par_w;
  logic                  bit_end;

  uart_tx_parity #(.DATA_WIDTH(DATA_WIDTH)) u_par (
    .data_i   (bus.P_DATA),
    .par_typ_i(bus.PAR_TYP),
    .par_o    (par_w)
  );

  assign bit_end    = cnt_q == pre_q - 6'd1;
  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = bit_end ? 6'd0 : cnt_q + 6'd1;
    pre_d    = pre_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    par_en_d = par_en_q;
    case (state_q)
      IDLE: begin
        cnt_d = 6'd0;
        if (bus.Data_Valid) begin
          state_d  = START;
          bit_d    = 4'd0;
          shift_d  = bus.P_DATA;
          par_d    = par_w;
          par_en_d = bus.PAR_EN;
          pre_d    = eff_prescale(bus.Prescale);
        end
      end
      START:  state_d = bit_end ? DATA : START;
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = (bit_q == 4'(DATA_WIDTH - 1)) ? 4'd0 : bit_q + 4'd1;
          state_d = (bit_q != 4'(DATA_WIDTH - 1)) ? DATA : par_en_q ? PARITY : STOP;
        end
      end
      PARITY: state_d = bit_end ? STOP : PARITY;
      STOP:   state_d = bit_end ? IDLE : STOP;
      default: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
    endcase
    // Outputs are registered from the next state so the line changes on the same edge as the state.
    tx_d   = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] :
             (state_d == PARITY) ? par_d : 1'b1;
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      pre_q    <= 6'd0;
      bit_q    <= 4'd0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pre_q    <= pre_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      par_en_q <= par_en_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: random and directed frames checked by a scoreboard against a bit-list model.
module tb_uart_tx_frame;
  typedef struct {
    logic [15:0] bits;
    int          n;
    int          p;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   free_at = 0;
  exp_t sb[$];
  logic samples[$];
  logic cap = 1'b0;
  int   cap_start = 0;

  uart_tx_frame_if #(.DATA_WIDTH(8)) bus ();
  uart_tx_frame #(.DATA_WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
    exp_t e;
    int ones = 0;
    e.p = (ps == 0) ? 1 : int'(ps);
    e.bits = '0;
    e.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e.bits[1 + i] = d[i];
      ones += int'(d[i]);
    end
    e.n = 9;
    if (pe) begin
      e.bits[e.n] = ((ones % 2) == 1) != pt;
      e.n++;
    end
    e.bits[e.n] = 1'b1;
    e.n++;
    e.acc = 0;
    return e;
  endfunction

  task automatic check_frame();
    exp_t e;
    if (sb.size() == 0) begin
      chk("unexpected_frame", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("frame_start_cycle", cap_start, e.acc);
    chk("busy_cycles", samples.size(), e.n * e.p);
    for (int j = 0; j < e.n; j++) begin
      int act = int'(e.bits[j]);
      for (int k = 0; k < e.p; k++)
        if (j * e.p + k < samples.size() && samples[j * e.p + k] != e.bits[j])
          act = int'(samples[j * e.p + k]);
      chk($sformatf("bit%0d_of_frame_at_%0d", j, e.acc), act, int'(e.bits[j]));
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      cap = 1'b0;
      samples.delete();
    end else if (bus.Busy) begin
      if (!cap) begin
        cap = 1'b1;
        cap_start = cyc;
      end
      samples.push_back(bus.TX_OUT);
    end else begin
      if (cap) begin
        check_frame();
        cap = 1'b0;
        samples.delete();
      end
      if (bus.TX_OUT !== 1'b1) chk("idle_line_high", int'(bus.TX_OUT), 1);
    end
  end

  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps,
                      input int gap, output int acc);
    exp_t e;
    while (cyc < free_at) @(negedge clk);
    bus.P_DATA = d;
    bus.PAR_EN = pe;
    bus.PAR_TYP = pt;
    bus.Prescale = ps;
    bus.Data_Valid = 1'b1;
    e = model(d, pe, pt, ps);
    e.acc = cyc + 1;
    acc = e.acc;
    sb.push_back(e);
    free_at = e.acc + e.n * e.p + gap;
    @(negedge clk);
    bus.Data_Valid = 1'b0;
    bus.P_DATA = 8'($urandom);
    bus.PAR_EN = 1'($urandom);
    bus.PAR_TYP = 1'($urandom);
    bus.Prescale = 6'($urandom);
  endtask

  task automatic held_high();
    exp_t e1, e2;
    logic [7:0] d;
    logic pe, pt;
    logic [5:0] ps;
    while (cyc < free_at) @(negedge clk);
    d = 8'($urandom);
    bus.P_DATA = d;
    bus.PAR_EN = 1'b1;
    bus.PAR_TYP = 1'b0;
    bus.Prescale = 6'd3;
    bus.Data_Valid = 1'b1;
    e1 = model(d, 1'b1, 1'b0, 6'd3);
    e1.acc = cyc + 1;
    sb.push_back(e1);
    while (cyc < e1.acc + 2) @(negedge clk);
    d = ~d;
    pe = 1'($urandom);
    pt = 1'($urandom);
    ps = 6'($urandom_range(1, 4));
    bus.P_DATA = d;
    bus.PAR_EN = pe;
    bus.PAR_TYP = pt;
    bus.Prescale = ps;
    e2 = model(d, pe, pt, ps);
    e2.acc = e1.acc + e1.n * e1.p + 1;
    sb.push_back(e2);
    while (cyc < e2.acc) @(negedge clk);
    bus.Data_Valid = 1'b0;
    free_at = e2.acc + e2.n * e2.p;
  endtask

  initial begin
    int acc;
    int t;
    bus.P_DATA = '0;
    bus.Data_Valid = 1'b0;
    bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0;
    bus.Prescale = '0;
    repeat (2) @(negedge clk);
    chk("reset_tx_out", int'(bus.TX_OUT), 1);
    chk("reset_busy", int'(bus.Busy), 0);
    rst_n = 1'b1;
    free_at = cyc + 1;
    send(8'hA5, 1'b1, 1'b0, 6'd8, 0, acc);
    send(8'hA5, 1'b1, 1'b1, 6'd8, 1, acc);
    send(8'hA5, 1'b0, 1'b0, 6'd8, 2, acc);
    send(8'hFF, 1'b1, 1'b0, 6'd16, 0, acc);
    send(8'h00, 1'b1, 1'b0, 6'd16, 1, acc);
    send(8'h00, 1'b1, 1'b1, 6'd16, 0, acc);
    send(8'h6B, 1'b1, 1'b1, 6'd0, 0, acc);
    send(8'h94, 1'b1, 1'b0, 6'd1, 0, acc);
    held_high();
    send(8'hC3, 1'b1, 1'b0, 6'd4, 0, acc);
    while (cyc < acc + 4 * 4 + 1) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_tx_out", int'(bus.TX_OUT), 1);
    chk("abort_busy", int'(bus.Busy), 0);
    @(negedge clk);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    free_at = cyc;
    send(8'h3C, 1'b1, 1'b0, 6'd4, 0, acc);
    for (int i = 0; i < 20; i++)
      send(8'($urandom), 1'($urandom), 1'($urandom), 6'($urandom_range(0, 5)),
           $urandom_range(0, 2), acc);
    held_high();
    t = 0;
    while ((sb.size() != 0 || bus.Busy) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", int'(t >= 5000), 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
